// File: rtl/txpath.sv
// UART-style frame transmitter: sends one of two fixed bytes (start, 8 data LSB first, stop).
// Define TXPATH_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module txpath #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [7:0]  BYTE0        = 8'hA5,
  parameter logic [7:0]  BYTE1        = 8'h3D
) (
  input  logic clk_8mhz,
  input  logic rst,
  input  logic which_byte,
  input  logic trigger,
  output logic tx_wire,
  output logic done
);

  localparam int unsigned     CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef TXPATH_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk_8mhz or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      tx_d = 1'b1;
      if (trigger) begin
        state_d = StStart;
        byte_d  = which_byte ? BYTE1 : BYTE0;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
      end
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      // Bit boundary: the line value for the next bit is registered here.
      cnt_d = '0;
      unique case (state_q)
        StStart: begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = byte_q[0];
        end
        StData: begin
          if (bit_q == 3'd7) begin
`ifdef TXPATH_PARITY_EN
            state_d = StParity;
            tx_d    = ^byte_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_d];
          end
        end
`ifdef TXPATH_PARITY_EN
        StParity: begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
`endif
        StStop: begin
          state_d = StIdle;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
        default: begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  assign tx_wire = tx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_txpath.sv
// Self-checking bench for txpath: random frames compared against a bit-list model of the frame.
module tb_txpath;

  localparam int unsigned N = 8;
`ifdef TXPATH_PARITY_EN
  localparam int unsigned L = 11;
`else
  localparam int unsigned L = 10;
`endif
  localparam logic [7:0] B0 = 8'hA5;
  localparam logic [7:0] B1 = 8'h3D;

  logic clk_8mhz = 1'b0;
  logic rst = 1'b0;
  logic which_byte = 1'b0;
  logic trigger = 1'b0;
  logic tx_wire;
  logic done;

  int tests = 0;
  int fails = 0;
  bit exp_bits[$];

  txpath #(
    .CLKS_PER_BIT(N),
    .BYTE0       (B0),
    .BYTE1       (B1)
  ) dut (
    .clk_8mhz  (clk_8mhz),
    .rst       (rst),
    .which_byte(which_byte),
    .trigger   (trigger),
    .tx_wire   (tx_wire),
    .done      (done)
  );

  always #5 clk_8mhz = ~clk_8mhz;

  // Model: the frame as an ordered list of line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] b);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef TXPATH_PARITY_EN
    exp_bits.push_back(($countones(b) % 2) == 1);
`endif
    exp_bits.push_back(1'b1);
  endfunction

  // Entered #1 after a posedge with the DUT idle; the next posedge is E0.
  // Returns #1 after the done edge with trigger driven to 'keep'.
  task automatic send_frame(input bit wb, input bit noise, input bit keep);
    which_byte = wb;
    trigger    = 1'b1;
    build_frame(wb ? B1 : B0);
    for (int k = 0; k <= int'(L * N); k++) begin
      @(posedge clk_8mhz);
      #1;
      tests++;
      if (k < int'(L * N)) begin
        if (tx_wire !== exp_bits[k / N] || done !== 1'b0) begin
          fails++;
          $display("FAIL frame wb=%0d k=%0d: tx=%b done=%b, want tx=%b done=0",
                   wb, k, tx_wire, done, exp_bits[k / N]);
        end
      end else if (tx_wire !== 1'b1 || done !== 1'b1) begin
        fails++;
        $display("FAIL done_pulse wb=%0d: tx=%b done=%b, want tx=1 done=1", wb, tx_wire, done);
      end
      if (k < int'(L * N)) begin
        trigger    = keep ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
        which_byte = noise ? 1'($urandom_range(0, 1)) : wb;
      end else begin
        trigger = keep;
      end
    end
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_8mhz);
      #1;
      tests++;
      if (tx_wire !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s c=%0d: tx=%b done=%b, want tx=1 done=0", tag, c, tx_wire, done);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    tests++;
    if (tx_wire !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: tx=%b done=%b, want tx=1 done=0", tx_wire, done);
    end
    repeat (2) @(posedge clk_8mhz);
    #1 rst = 1'b0;
    idle_check(5, "reset_idle");
    // Abort a frame part way through.
    which_byte = 1'($urandom_range(0, 1));
    trigger    = 1'b1;
    @(posedge clk_8mhz);
    #1 trigger = 1'b0;
    repeat ($urandom_range(1, L * N - 3)) @(posedge clk_8mhz);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (tx_wire !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_midframe: tx=%b done=%b, want tx=1 done=0", tx_wire, done);
    end
    @(posedge clk_8mhz);
    #1 rst = 1'b0;
    idle_check(L * N + 20, "reset_no_done");
    send_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle_check(3, "reset_after");
  endtask

  task automatic test_byte0();
    send_frame(1'b0, 1'b0, 1'b0);
    idle_check(4, "byte0_after");
  endtask

  task automatic test_byte1();
    idle_check(100 - L * N, "byte1_gap");
    send_frame(1'b1, 1'b0, 1'b0);
    idle_check(4, "byte1_after");
  endtask

  task automatic test_ignore();
    for (int r = 0; r < 3; r++) begin
      send_frame(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      idle_check(2 * N, "ignore_no_second");
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) send_frame(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    send_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle_check(4, "b2b_after");
  endtask

  initial begin
    test_reset();
    test_byte0();
    test_byte1();
    test_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/txpath.md
TXPATH -- requirements
Module: txpath

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT, default 8, SHALL set the clk_8mhz cycles per serial bit (legal 2..65535).
REQ-003 Parameter BYTE0, default 8'hA5, SHALL be the byte sent when which_byte=0.
REQ-004 Parameter BYTE1, default 8'h3D, SHALL be the byte sent when which_byte=1.
REQ-005 Port clk_8mhz, input, 1 bit, SHALL be the 8 MHz system clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-007 Port which_byte, input, 1 bit, SHALL select BYTE0 (0) or BYTE1 (1).
REQ-008 Port trigger, input, 1 bit, SHALL request transmission of one frame.
REQ-009 Port tx_wire, output, 1 bit, SHALL be the registered UART serial line, idle high.
REQ-010 Port done, output, 1 bit, SHALL be a registered one-cycle end-of-frame pulse.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, [PARITY], STOP.
REQ-012 In IDLE, tx_wire=1 and done=0 except during the done pulse.
REQ-013 Edge E0 with state IDLE and trigger=1 SHALL latch the selected byte (which_byte sampled at E0 only), enter START, and drive tx_wire=0 from E0.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles: start from E0, data bit i (LSB first, i=0..7) from E0+(1+i)*N, stop (1) from E0+9*N; N=CLKS_PER_BIT.
REQ-015 At end of stop bit (E0+10*N, or E0+11*N with parity) the FSM SHALL return to IDLE, tx_wire=1, done=1 for exactly one cycle.
REQ-016 trigger SHALL be level-sampled; trigger held high SHALL start a new frame at the first IDLE edge after the done pulse, i.e. one cycle after done rises.
REQ-017 trigger and which_byte changes while not IDLE (including on the edge done rises) SHALL be ignored; no queuing.
REQ-018 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at every bit boundary.
REQ-019 tx_wire SHALL be glitch-free (driven from a flop, no combinational path from inputs).

Reset
REQ-020 While rst=1 (asynchronously): state IDLE, tx_wire=1, done=0, counters 0, latched byte 0.
REQ-021 rst asserted mid-frame SHALL abort the frame with no done pulse; first trigger after rst release starts a full new frame.

Configuration
REQ-022 Macro TXPATH_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent for N cycles between data bit 7 and stop, frame length 11*N, done at E0+11*N.
REQ-023 Macro TXPATH_PARITY_EN undefined: PARITY state and logic SHALL be absent, frame length 10*N.

Verification
REQ-024 Reset: rst=1 mid-frame -> tx_wire=1, done=0 immediately; no done pulse follows.
REQ-025 N=8, trigger one cycle with which_byte=0 -> tx_wire 0,1,0,1,0,0,1,0,1,1 each for 8 cycles (start, A5 LSB first, stop); done one cycle at E0+80.
REQ-026 which_byte=1, trigger pulse 100 cycles after first -> 0,1,0,1,1,1,1,0,0,1 (3D); done at E0+80.
REQ-027 Toggle which_byte and pulse trigger during a frame -> frame content unchanged, no second frame.
REQ-028 trigger held high -> back-to-back frames, second start bit one cycle after done.
REQ-029 TXPATH_PARITY_EN defined: BYTE0 -> parity bit 0; BYTE1 -> parity bit 1; done at E0+88.
